fft_ctrl: RTL and testbench

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_ctrl_if.sv | 27 ++
 rtl/fft_ctrl.sv | 128 ++++++++++++
 tb/tb_fft_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_if.sv
// fft_ctrl_if: control/datapath bundle between fft_ctrl and the FFT data RAM, twiddle ROM and butterfly
//   master (fft_ctrl): drives busy/done/rd_*/tw_addr/bf_en/wr_*/stage/err, samples start/bf_valid[/abort]
//   slave (datapath/env): the mirror image
//   abort exists only when FFT_CTRL_ABORT_EN is defined
interface fft_ctrl_if #(parameter int N_LOG2 = 10);
    localparam int TW_LOG2 = N_LOG2 - 1;
    logic start, busy, done, rd_en, bf_en, bf_valid, wr_en, err;
    logic [N_LOG2-1:0] rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q;
    logic [TW_LOG2-1:0] tw_addr;
    logic [3:0] stage;
`ifdef FFT_CTRL_ABORT_EN
    logic abort;
    modport master (input start, bf_valid, abort,
                    output busy, done, rd_en, rd_addr_p, rd_addr_q, tw_addr, bf_en,
                           wr_en, wr_addr_p, wr_addr_q, stage, err);
    modport slave (output start, bf_valid, abort,
                   input busy, done, rd_en, rd_addr_p, rd_addr_q, tw_addr, bf_en,
                         wr_en, wr_addr_p, wr_addr_q, stage, err);
`else
    modport master (input start, bf_valid,
                    output busy, done, rd_en, rd_addr_p, rd_addr_q, tw_addr, bf_en,
                           wr_en, wr_addr_p, wr_addr_q, stage, err);
    modport slave (output start, bf_valid,
                   input busy, done, rd_en, rd_addr_p, rd_addr_q, tw_addr, bf_en,
                         wr_en, wr_addr_p, wr_addr_q, stage, err);
`endif
endinterface

// File: rtl/fft_ctrl.sv
// fft_ctrl: radix-2 in-place FFT sequencer issuing one butterfly per cycle, stage by stage
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fft_ctrl_if.master (start/busy/done, read/twiddle/butterfly/write strobes and addresses, stage, err)
//   FFT_CTRL_ABORT_EN : when defined, bus.abort stops issue, lets in-flight writes finish, returns to IDLE without done
module fft_ctrl #(
    parameter int N_LOG2 = 10,
    localparam int TW_LOG2 = N_LOG2 - 1
) (
    input logic clk,
    input logic rst_n,
    fft_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [TW_LOG2-1:0] k_q, k_d, tw_q, tw_d;
    logic [3:0] stage_q, stage_d;
    logic abt_q, abt_d, iss, last_wb, ab;
    logic rd_en_q, bf_en_q, v2_q, wr_en_q, busy_q, done_q, err_q;
    logic [N_LOG2-1:0] rp_q, rq_q, p1_q, q1_q, p2_q, q2_q, wp_q, wq_q, p_d, q_d, kx, j;
`ifdef FFT_CTRL_ABORT_EN
    assign ab = bus.abort;
`else
    assign ab = 1'b0;
`endif
    // the stage's last write-back is the one with nothing left behind it in the pipe
    assign last_wb = wr_en_q && !v2_q && !bf_en_q;
    always_comb begin
        state_d = state_q;
        k_d = k_q;
        stage_d = stage_q;
        abt_d = abt_q;
        iss = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                k_d = '0;
                stage_d = '0;
                abt_d = 1'b0;
                iss = 1'b1;
            end
            RUN: if (ab) begin
                state_d = DRAIN;
                abt_d = 1'b1;
            end else if (k_q == '1) state_d = DRAIN;
            else begin
                k_d = k_q + 1'b1;
                iss = 1'b1;
            end
            DRAIN: if (last_wb) begin
                if (abt_q || ab) state_d = IDLE;
                else if (stage_q == 4'(N_LOG2 - 1)) state_d = DONE;
                else begin
                    state_d = RUN;
                    k_d = '0;
                    stage_d = stage_q + 1'b1;
                    iss = 1'b1;
                end
            end else if (ab) abt_d = 1'b1;
            default: state_d = IDLE;
        endcase
        // k splits into group (upper bits) and offset j (low stage bits); p inserts a 0 at bit s, q a 1
        kx = {1'b0, k_d};
        j = kx & ((N_LOG2'(1) << stage_d) - N_LOG2'(1));
        p_d = ((kx >> stage_d) << (stage_d + 4'd1)) | j;
        q_d = p_d | (N_LOG2'(1) << stage_d);
        tw_d = TW_LOG2'(j << (4'(TW_LOG2) - stage_d));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q <= '0;
            stage_q <= '0;
            abt_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            rd_en_q <= 1'b0;
            bf_en_q <= 1'b0;
            v2_q <= 1'b0;
            wr_en_q <= 1'b0;
            rp_q <= '0;
            rq_q <= '0;
            tw_q <= '0;
            p1_q <= '0;
            q1_q <= '0;
            p2_q <= '0;
            q2_q <= '0;
            wp_q <= '0;
            wq_q <= '0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            stage_q <= stage_d;
            abt_q <= abt_d;
            busy_q <= state_d == RUN || state_d == DRAIN;
            done_q <= state_d == DONE;
            err_q <= (state_q == IDLE && bus.start) ? 1'b0 : err_q | (bus.bf_valid != wr_en_q);
            rd_en_q <= iss;
            if (iss) begin
                rp_q <= p_d;
                rq_q <= q_d;
                tw_q <= tw_d;
            end
            // read addresses already hold between issues, so a plain delay keeps write addresses held too
            bf_en_q <= rd_en_q;
            v2_q <= bf_en_q;
            wr_en_q <= v2_q;
            p1_q <= rp_q;
            q1_q <= rq_q;
            p2_q <= p1_q;
            q2_q <= q1_q;
            wp_q <= p2_q;
            wq_q <= q2_q;
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err = err_q;
    assign bus.stage = stage_q;
    assign bus.rd_en = rd_en_q;
    assign bus.rd_addr_p = rp_q;
    assign bus.rd_addr_q = rq_q;
    assign bus.tw_addr = tw_q;
    assign bus.bf_en = bf_en_q;
    assign bus.wr_en = wr_en_q;
    assign bus.wr_addr_p = wp_q;
    assign bus.wr_addr_q = wq_q;
endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: scoreboard bench for fft_ctrl at N_LOG2=3 against a loop-based butterfly schedule model
module tb_fft_ctrl;
    localparam int L = 3, N = 8, H = 4, P = H + 3, T_END = L * P;
    typedef struct packed {logic [2:0] p, q; logic [1:0] tw;} rd_t;
    typedef struct packed {logic [2:0] p, q;} wr_t;
    logic clk = 1'b0, rst_n = 1'b0, act = 1'b0, err_exp = 1'b0;
    int cyc = 0, t0 = 0, kill_c = -1, ab = -1, checks = 0, failures = 0, mr;
    rd_t rdq[$];
    wr_t wrq[$];
    rd_t me;
    wr_t mw;
    fft_ctrl_if #(.N_LOG2(L)) ifc();
    fft_ctrl #(.N_LOG2(L)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb ifc.bf_valid = ifc.wr_en ^ (act && (cyc - t0 == kill_c));
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", n, a, e, cyc - t0);
        end
    endtask
    function automatic logic e_rd(input int r);
        return r >= 1 && (r - 1) % P < H && (r - 1) / P < L && (ab < 0 || r <= ab);
    endfunction
    function automatic logic e_busy(input int r);
        return r >= 1 && r <= (ab < 0 ? T_END : ab + 3);
    endfunction
    function automatic logic e_done(input int r);
        return ab < 0 && r == T_END + 1;
    endfunction
    function automatic int e_stage(input int r);
        return ab >= 0 ? 0 : ((r - 1) / P < L ? (r - 1) / P : L - 1);
    endfunction
    // butterfly order: stage, then group of 2*half points, then offset inside the group
    task automatic push_model(input int nrd);
        int n = 0;
        rd_t r;
        wr_t w;
        for (int s = 0; s < L; s++)
            for (int g = 0; g < N; g += 2 << s)
                for (int jj = 0; jj < (1 << s); jj++) begin
                    r = '{p: 3'(g + jj), q: 3'(g + jj + (1 << s)), tw: 2'(jj * (N / (2 << s)))};
                    w = '{p: r.p, q: r.q};
                    if (n < nrd) begin
                        rdq.push_back(r);
                        wrq.push_back(w);
                    end
                    n++;
                end
    endtask
    task automatic chk_zero(input string t);
        chk({t, "_rd_en"}, ifc.rd_en, 0);
        chk({t, "_bf_en"}, ifc.bf_en, 0);
        chk({t, "_wr_en"}, ifc.wr_en, 0);
        chk({t, "_busy"}, ifc.busy, 0);
        chk({t, "_done"}, ifc.done, 0);
        chk({t, "_err"}, ifc.err, 0);
        chk({t, "_stage"}, ifc.stage, 0);
        chk({t, "_rd_p"}, ifc.rd_addr_p, 0);
        chk({t, "_rd_q"}, ifc.rd_addr_q, 0);
        chk({t, "_tw"}, ifc.tw_addr, 0);
        chk({t, "_wr_p"}, ifc.wr_addr_p, 0);
        chk({t, "_wr_q"}, ifc.wr_addr_q, 0);
    endtask
    always @(negedge clk) if (act) begin
        mr = cyc - t0;
        chk("rd_en", ifc.rd_en, e_rd(mr));
        chk("bf_en", ifc.bf_en, e_rd(mr - 1));
        chk("wr_en", ifc.wr_en, e_rd(mr - 3));
        chk("busy", ifc.busy, e_busy(mr));
        chk("done", ifc.done, e_done(mr));
        if (mr >= 1) begin
            chk("stage", ifc.stage, e_stage(mr));
            chk("err", ifc.err, err_exp);
        end
        if (mr == kill_c) err_exp = 1'b1;
        if (ifc.rd_en) begin
            if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                me = rdq.pop_front();
                chk("rd_addr_p", ifc.rd_addr_p, me.p);
                chk("rd_addr_q", ifc.rd_addr_q, me.q);
                chk("tw_addr", ifc.tw_addr, me.tw);
            end
        end
        if (ifc.wr_en) begin
            if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                mw = wrq.pop_front();
                chk("wr_addr_p", ifc.wr_addr_p, mw.p);
                chk("wr_addr_q", ifc.wr_addr_q, mw.q);
            end
        end
    end
    task automatic begin_xfer(input int kc, input int abt);
        @(posedge clk);
        #1;
        ab = abt;
        kill_c = kc;
        push_model(abt < 0 ? L * H : abt);
        t0 = cyc;
        err_exp = 1'b0;
        act = 1'b1;
        ifc.start = 1'b1;
    endtask
    task automatic run_xfer(input int spur, input int kc, input int abt);
        begin_xfer(kc, abt);
        while (cyc - t0 <= T_END + 2) begin
            @(posedge clk);
            #1;
            ifc.start = (cyc - t0 == spur);
`ifdef FFT_CTRL_ABORT_EN
            ifc.abort = (cyc - t0 == ab);
`endif
        end
        ifc.start = 1'b0;
        act = 1'b0;
        chk("rd_queue_left", rdq.size(), 0);
        chk("wr_queue_left", wrq.size(), 0);
        rdq.delete();
        wrq.delete();
    endtask
    initial begin
        int spur, kc, a;
        ifc.start = 1'b0;
`ifdef FFT_CTRL_ABORT_EN
        ifc.abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        run_xfer(-1, -1, -1);
        // kill the bf_valid of stage 1, k=2 (issued at rel 10, written at rel 13); spurious start at 5
        run_xfer(5, 13, -1);
        begin_xfer(-1, -1);
        while (cyc - t0 < 10) begin
            @(posedge clk);
            #1;
            ifc.start = (cyc - t0 == 5);
        end
        act = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        rdq.delete();
        wrq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_reset_wr_en", ifc.wr_en, 0);
            chk("post_reset_rd_en", ifc.rd_en, 0);
        end
`ifdef FFT_CTRL_ABORT_EN
        run_xfer(-1, -1, 3);
`endif
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a = -1;
`ifdef FFT_CTRL_ABORT_EN
            if ($urandom_range(0, 2) == 0) a = $urandom_range(1, H);
`endif
            spur = (a < 0 && $urandom_range(0, 1) == 1) ? $urandom_range(2, T_END) : -1;
            kc = (a < 0 && $urandom_range(0, 1) == 1) ? 4 + P * $urandom_range(0, L - 1) + $urandom_range(0, H - 1) : -1;
            run_xfer(spur, kc, a);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
